// File: rtl/cs_arb_pkg.sv
// Shared types and sizing for the chip-select round-robin arbiter.
package cs_arb_pkg;

  localparam int N_CS  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/cs_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the chip-select arbiter.
interface cs_rr_arbiter_if;
  import cs_arb_pkg::*;

  logic              en;
  logic [N_CS-1:0]   req;
  logic [N_CS-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              timeout;

  modport slave (
    input  en, req,
    output grant, grant_idx, grant_valid, timeout
  );

  modport master (
    output en, req,
    input  grant, grant_idx, grant_valid, timeout
  );

endinterface

// File: rtl/cs_rr_arbiter_dec.sv
// 3-to-8 enable decoder: one-hot y from index x, all zero when en is low.
module cs_rr_arbiter_dec
  import cs_arb_pkg::*;
(
  input  logic [IDX_W-1:0] x,
  input  logic             en,
  output logic [N_CS-1:0]  y
);

  always_comb begin
    y = '0;
    if (en) y[x] = 1'b1;
  end

endmodule

// File: rtl/cs_rr_arbiter.sv
// Round-robin arbiter for an 8-way chip select with hold limit and a dead
// cycle between grants so no two selects ever overlap.
module cs_rr_arbiter
  import cs_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  cs_rr_arbiter_if.slave   bus
);

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]    grant_idx_q;
  logic                grant_valid_q;
  logic                timeout_q;

  logic [IDX_W-1:0]    winner;
  logic                cur_req;
  logic                at_limit;
  logic                release_now;

  // Scans offsets high-to-low so the lowest offset from ptr wins last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CS-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    rr_pick = p;
    for (int unsigned k = N_CS; k > 0; k--) begin
      idx = p + IDX_W'(k - 1);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner      = rr_pick(bus.req, ptr);
  assign cur_req     = bus.req[grant_idx_q];
  assign at_limit    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_now = !cur_req || !bus.en || at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && (|bus.req)) begin
            state         <= GRANT;
            grant_idx_q   <= winner;
            grant_valid_q <= 1'b1;
            hold_cnt      <= '0;
          end
        end
        GRANT: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
          if (release_now) begin
            state         <= GAP;
            grant_valid_q <= 1'b0;
            ptr           <= grant_idx_q + 1'b1;
            // Only a limit-forced release of a still-requesting, enabled owner counts.
            timeout_q     <= bus.en && cur_req && at_limit;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

  cs_rr_arbiter_dec u_dec (
    .x  (grant_idx_q),
    .en (grant_valid_q),
    .y  (bus.grant)
  );

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// Directed checks of the chip-select round-robin arbiter with MAX_HOLD=4.
module tb_cs_rr_arbiter;
  import cs_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  cs_rr_arbiter_if bus ();

  cs_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_g(input string tag, input logic [7:0] g, input logic [2:0] idx,
                       input logic v, input logic to);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".idx"},   32'(bus.grant_idx), 32'(idx));
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
    chk({tag, ".tmo"},   32'(bus.timeout), 32'(to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] idx;
    logic [7:0] e;

    // reset / basic grant
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.req = 8'hFF;
    #3;
    chk_g("rst0", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_g("rst1", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n   = 1'b1;
    bus.req = 8'h01;
    tick();
    chk_g("basic", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    chk_g("basic_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_g("basic_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_g("basic_idle2", 8'h00, 3'd0, 1'b0, 1'b0);

    // fairness with all requesting: restart from ptr=0
    rst_n = 1'b0;
    #2;
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      idx = 3'(k % 8);
      e   = 8'h01 << idx;
      for (int c = 0; c < 4; c++) begin
        if (c > 0) tick();
        chk_g("fair", e, idx, 1'b1, 1'b0);
      end
      tick();
      chk_g("fair_to", 8'h00, idx, 1'b0, 1'b1);
      if (k == 8) bus.req = 8'h00;
      tick();
      chk_g("fair_gap", 8'h00, idx, 1'b0, 1'b0);
      if (k < 8) tick();
    end

    // pointer wrap and skip: grant idx5 -> ptr 6, then req 09
    bus.req = 8'h20;
    tick();
    chk_g("wrap_g5", 8'h20, 3'd5, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    chk_g("wrap_rel5", 8'h00, 3'd5, 1'b0, 1'b0);
    tick();
    bus.req = 8'h09;
    tick();
    chk_g("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_g("wrap_hold0", 8'h01, 3'd0, 1'b1, 1'b0);
    end
    tick();
    chk_g("wrap_to0", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk_g("wrap_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_g("wrap_g3", 8'h08, 3'd3, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    chk_g("wrap_rel3", 8'h00, 3'd3, 1'b0, 1'b0);
    tick();

    // early release after 3 cycles (ptr=4 -> winner 2)
    bus.req = 8'h04;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_g("early", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    bus.req = 8'h00;
    tick();
    chk_g("early_rel", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();
    bus.req = 8'h0C;
    tick();
    chk_g("early_ptr3", 8'h08, 3'd3, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    tick();

    // en drop mid-grant
    bus.req = 8'h80;
    tick();
    chk_g("en_g7", 8'h80, 3'd7, 1'b1, 1'b0);
    tick();
    chk_g("en_g7b", 8'h80, 3'd7, 1'b1, 1'b0);
    bus.en = 1'b0;
    tick();
    chk_g("en_rel", 8'h00, 3'd7, 1'b0, 1'b0);
    bus.req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_g("en_block", 8'h00, 3'd7, 1'b0, 1'b0);
    end
    bus.en = 1'b1;
    tick();
    chk_g("en_resume", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    tick();

    // async reset mid-grant
    bus.req = 8'h10;
    tick();
    chk_g("ar_g4", 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_g("ar_async", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_g("ar_held", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_g("ar_regrant", 8'h10, 3'd4, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    chk_g("ar_rel", 8'h00, 3'd4, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
